// File: rtl/usb_tx_sched.sv
// ----------------------------------------------------------------------------
// usb_tx_sched
//
// Transmit-side scheduler for the single DP/DM write path. It arbitrates
// between the token, data and handshake encoders. The grant stays with one
// source for a whole packet. The block drives the writer's bitstream,
// bitstream-ready and packet-type inputs. After the last data bit it times
// the EOP/J tail, then holds an idle gap before the next grant.
//
// Build option:
//   USB_SCHED_RR_EN  when defined, hs keeps absolute priority and tok/data
//                    ties alternate using a last-winner flag. The flag resets
//                    to "data last", so tok wins the first tie. When the macro
//                    is undefined, priority is fixed at hs > tok > data.
//
// Ports:
//   clk             system clock
//   rst_b           synchronous active-low reset
//   tok_req         token source has a packet pending
//   data_req        data source has a packet pending
//   hs_req          handshake source has a packet pending
//   tok_bit         token source's current serial bit
//   data_bit        data source's current serial bit
//   hs_bit          handshake source's current serial bit
//   tok_gnt         token source owns the writer
//   data_gnt        data source owns the writer
//   hs_gnt          handshake source owns the writer
//   bit_adv         granted source shifts to its next bit on this edge
//   bstr_out        bit to the DP/DM writer
//   bstr_out_ready  writer packet window (packet bits plus tail)
//   p_type          00 none, 01 token, 10 data, 11 handshake
//   busy            scheduler is not idle
//   pkt_done        one-cycle pulse on the last tail cycle
//
// Handshake: a source raises *_req and holds it until it sees its *_gnt
// fall. While *_gnt is high, the source presents its current bit on *_bit.
// It advances to the next bit on every clock edge where bit_adv is high.
// Requests are sampled only in IDLE and are never queued internally.
// ----------------------------------------------------------------------------
module usb_tx_sched #(
    parameter int TOK_BITS  = 28,
    parameter int DATA_BITS = 92,
    parameter int HS_BITS   = 12,
    parameter int TAIL_BITS = 3,
    parameter int GAP_BITS  = 2
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       tok_req,
    input  logic       data_req,
    input  logic       hs_req,
    input  logic       tok_bit,
    input  logic       data_bit,
    input  logic       hs_bit,
    output logic       tok_gnt,
    output logic       data_gnt,
    output logic       hs_gnt,
    output logic       bit_adv,
    output logic       bstr_out,
    output logic       bstr_out_ready,
    output logic [1:0] p_type,
    output logic       busy,
    output logic       pkt_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        TAIL = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [1:0] PT_NONE = 2'b00;
    localparam logic [1:0] PT_TOK  = 2'b01;
    localparam logic [1:0] PT_DATA = 2'b10;
    localparam logic [1:0] PT_HS   = 2'b11;

    localparam logic [6:0] TOK_LEN   = 7'(TOK_BITS);
    localparam logic [6:0] DATA_LEN  = 7'(DATA_BITS);
    localparam logic [6:0] HS_LEN    = 7'(HS_BITS);
    localparam logic [6:0] TAIL_LAST = 7'(TAIL_BITS - 1);
    localparam logic [6:0] GAP_LAST  = 7'(GAP_BITS - 1);

    state_t     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic [6:0] len_q, len_d;
    // The registered packet type also encodes the grant owner. It is cleared
    // on entry to GAP, so the grants and p_type drop together.
    logic [1:0] ptype_q, ptype_d;

    logic [1:0] win;
    logic [6:0] win_len;

`ifdef USB_SCHED_RR_EN
    // 1: tok won the last tok/data arbitration, 0: data did (reset value).
    logic last_tok_q;

    always_comb begin
        win = PT_NONE;
        if (hs_req)                    win = PT_HS;
        else if (tok_req && data_req)  win = last_tok_q ? PT_DATA : PT_TOK;
        else if (tok_req)              win = PT_TOK;
        else if (data_req)             win = PT_DATA;
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            last_tok_q <= 1'b0;
        end else if (state_q == IDLE && (win == PT_TOK || win == PT_DATA)) begin
            last_tok_q <= (win == PT_TOK);
        end
    end
`else
    always_comb begin
        win = PT_NONE;
        if (hs_req)        win = PT_HS;
        else if (tok_req)  win = PT_TOK;
        else if (data_req) win = PT_DATA;
    end
`endif

    always_comb begin
        case (win)
            PT_TOK:  win_len = TOK_LEN;
            PT_DATA: win_len = DATA_LEN;
            PT_HS:   win_len = HS_LEN;
            default: win_len = 7'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q <= IDLE;
            cnt_q   <= 7'd0;
            len_q   <= 7'd0;
            ptype_q <= PT_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ptype_q <= ptype_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ptype_d = ptype_q;
        case (state_q)
            IDLE: begin
                if (win != PT_NONE) begin
                    state_d = SEND;
                    ptype_d = win;
                    len_d   = win_len;
                    cnt_d   = 7'd0;
                end
            end
            SEND: begin
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == len_q - 7'd1) begin
                    state_d = TAIL;
                    cnt_d   = 7'd0;
                end
            end
            TAIL: begin
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == TAIL_LAST) begin
                    state_d = GAP;
                    cnt_d   = 7'd0;
                    ptype_d = PT_NONE;
                end
            end
            GAP: begin
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = 7'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 7'd0;
                ptype_d = PT_NONE;
            end
        endcase
    end

    always_comb begin
        tok_gnt        = (ptype_q == PT_TOK);
        data_gnt       = (ptype_q == PT_DATA);
        hs_gnt         = (ptype_q == PT_HS);
        p_type         = ptype_q;
        busy           = (state_q != IDLE);
        bit_adv        = 1'b0;
        bstr_out       = 1'b0;
        bstr_out_ready = 1'b0;
        pkt_done       = 1'b0;
        case (state_q)
            SEND: begin
                bit_adv        = 1'b1;
                bstr_out_ready = 1'b1;
                case (ptype_q)
                    PT_TOK:  bstr_out = tok_bit;
                    PT_DATA: bstr_out = data_bit;
                    PT_HS:   bstr_out = hs_bit;
                    default: bstr_out = 1'b0;
                endcase
            end
            TAIL: begin
                // SE0/J tail: the writer forms the line state; data stays 0.
                bstr_out_ready = 1'b1;
                pkt_done       = (cnt_q == TAIL_LAST);
            end
            default: begin
                bstr_out_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_usb_tx_sched.sv
// ----------------------------------------------------------------------------
// tb_usb_tx_sched
//
// Bench for usb_tx_sched. A reference model tracks the time since the last
// grant and derives the expected outputs for every cycle from the packet
// lengths. It pushes those expected outputs into exp_q. A monitor on the
// falling edge pops each entry and compares it with the DUT outputs. The
// monitor also consumes the directed checks that the main sequence queues.
// ----------------------------------------------------------------------------
module tb_usb_tx_sched;

  localparam int TOK_BITS  = 28;
  localparam int DATA_BITS = 92;
  localparam int HS_BITS   = 12;
  localparam int TAIL_BITS = 3;
  localparam int GAP_BITS  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  logic [2:0] reqv;       // {hs, data, tok}
  logic       tok_bit, data_bit, hs_bit;
  logic       tok_gnt, data_gnt, hs_gnt, bit_adv, bstr_out, bstr_out_ready;
  logic [1:0] p_type;
  logic       busy, pkt_done;

  usb_tx_sched dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .tok_req        (reqv[0]),
    .data_req       (reqv[1]),
    .hs_req         (reqv[2]),
    .tok_bit        (tok_bit),
    .data_bit       (data_bit),
    .hs_bit         (hs_bit),
    .tok_gnt        (tok_gnt),
    .data_gnt       (data_gnt),
    .hs_gnt         (hs_gnt),
    .bit_adv        (bit_adv),
    .bstr_out       (bstr_out),
    .bstr_out_ready (bstr_out_ready),
    .p_type         (p_type),
    .busy           (busy),
    .pkt_done       (pkt_done)
  );

  // ---------------- packet sources ----------------
  logic [127:0] pat_tok, pat_data, pat_hs;
  logic [6:0]   tok_idx = 7'd0, data_idx = 7'd0, hs_idx = 7'd0;

  assign tok_bit  = pat_tok[tok_idx];
  assign data_bit = pat_data[data_idx];
  assign hs_bit   = pat_hs[hs_idx];

  always @(posedge clk) begin
    if (tok_gnt && bit_adv) tok_idx <= tok_idx + 7'd1;
    else if (!tok_gnt)      tok_idx <= 7'd0;
    if (data_gnt && bit_adv) data_idx <= data_idx + 7'd1;
    else if (!data_gnt)      data_idx <= 7'd0;
    if (hs_gnt && bit_adv) hs_idx <= hs_idx + 7'd1;
    else if (!hs_gnt)      hs_idx <= 7'd0;
  end

  // ---------------- reference model ----------------
  logic [9:0] exp_q[$];
  bit         m_active = 1'b0;
  logic [1:0] m_win = 2'b00;
  int         m_t = 0;
  bit         m_last_tok = 1'b0;

  function automatic int plen(input logic [1:0] pt);
    if (pt == 2'b01) return TOK_BITS;
    if (pt == 2'b10) return DATA_BITS;
    return HS_BITS;
  endfunction

  function automatic logic [1:0] pick(input logic [2:0] r, input bit last_tok);
    if (r[2]) return 2'b11;
`ifdef USB_SCHED_RR_EN
    if (r[0] && r[1]) return last_tok ? 2'b10 : 2'b01;
`endif
    if (r[0]) return 2'b01;
    return 2'b10;
  endfunction

  // Output packing: {tok_gnt,data_gnt,hs_gnt,bit_adv,bstr,ready,p_type,busy,done}
  function automatic logic [9:0] model_out();
    logic [2:0] g;
    logic [127:0] pat;
    int len;
    if (!m_active) return 10'd0;
    len = plen(m_win);
    g   = {m_win == 2'b01, m_win == 2'b10, m_win == 2'b11};
    pat = (m_win == 2'b01) ? pat_tok : (m_win == 2'b10) ? pat_data : pat_hs;
    if (m_t < len)
      return {g, 1'b1, pat[m_t], 1'b1, m_win, 1'b1, 1'b0};
    if (m_t < len + TAIL_BITS)
      return {g, 1'b0, 1'b0, 1'b1, m_win, 1'b1, m_t == len + TAIL_BITS - 1};
    return {3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
  endfunction

  always @(posedge clk) begin
    if (!rst_b) begin
      m_active   = 1'b0;
      m_t        = 0;
      m_last_tok = 1'b0;
    end else if (m_active) begin
      m_t = m_t + 1;
      if (m_t >= plen(m_win) + TAIL_BITS + GAP_BITS) m_active = 1'b0;
    end else if (reqv != 3'b000) begin
      m_win  = pick(reqv, m_last_tok);
      m_active = 1'b1;
      m_t    = 0;
      if (m_win == 2'b01) m_last_tok = 1'b1;
      if (m_win == 2'b10) m_last_tok = 1'b0;
    end
    exp_q.push_back(model_out());
  end

  // ---------------- scoreboard / monitor ----------------
  int n_vec = 0;
  int n_err = 0;
  string dn_q[$];
  int    da_q[$];
  int    de_q[$];

  int g_type[$];
  int g_cyc[$];
  int cyc_n = 0;
  int adv_cnt = 0, done_cnt = 0, busy_cnt = 0, rdy_cnt = 0;
  bit gnt_prev = 1'b0;

  always @(negedge clk) begin
    logic [9:0] act;
    logic [9:0] e;
    cyc_n = cyc_n + 1;
    act = {tok_gnt, data_gnt, hs_gnt, bit_adv, bstr_out, bstr_out_ready,
           p_type, busy, pkt_done};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec = n_vec + 1;
      if (act !== e) begin
        n_err = n_err + 1;
        $display("FAIL outputs cycle %0d: got %b want %b (gnt t/d/h, adv, bit, rdy, ptype, busy, done)",
                 cyc_n, act, e);
      end
    end
    while (dn_q.size() > 0) begin
      string nm;
      int a, x;
      nm = dn_q.pop_front();
      a  = da_q.pop_front();
      x  = de_q.pop_front();
      n_vec = n_vec + 1;
      if (a != x) begin
        n_err = n_err + 1;
        $display("FAIL %s: got %0d want %0d", nm, a, x);
      end
    end
    if ((tok_gnt | data_gnt | hs_gnt) && !gnt_prev) begin
      g_type.push_back(int'(p_type));
      g_cyc.push_back(cyc_n);
    end
    gnt_prev = tok_gnt | data_gnt | hs_gnt;
    if (bit_adv)        adv_cnt  = adv_cnt + 1;
    if (pkt_done)       done_cnt = done_cnt + 1;
    if (busy)           busy_cnt = busy_cnt + 1;
    if (bstr_out_ready) rdy_cnt  = rdy_cnt + 1;
  end

  // ---------------- driver tasks ----------------
  bit   rand_en = 1'b0;
  bit   hold_en = 1'b0;
  bit [2:0] seen = 3'b000;

  task automatic push_chk(input string nm, input int a, input int x);
    dn_q.push_back(nm);
    da_q.push_back(a);
    de_q.push_back(x);
  endtask

  // Advance one clock. Sources drop their request once they see their own
  // grant fall. In random mode they also raise requests and reroll patterns.
  task automatic tick();
    logic [2:0] g;
    @(posedge clk);
    #1;
    g = {hs_gnt, data_gnt, tok_gnt};
    for (int s = 0; s < 3; s++) begin
      if (!reqv[s]) seen[s] = 1'b0;
      else if (g[s]) begin
        seen[s] = 1'b1;
        if (rand_en && $urandom_range(0, 63) == 0) begin
          reqv[s] = 1'b0;
          seen[s] = 1'b0;
        end
      end else if (seen[s] && !hold_en) begin
        reqv[s] = 1'b0;
        seen[s] = 1'b0;
      end
      if (rand_en && !reqv[s] && !g[s] && $urandom_range(0, 15) == 0)
        reqv[s] = 1'b1;
    end
    if (rand_en) begin
      if (!g[0]) pat_tok  = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (!g[1]) pat_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (!g[2]) pat_hs   = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
  endtask

  task automatic wait_quiet(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy && reqv == 3'b000) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) push_chk("wait_quiet_timeout", 1, 0);
  endtask

  // ---------------- main sequence ----------------
  int b, a0, d0, bz0, r0;

  initial begin
    rst_b    = 1'b0;
    reqv     = 3'b000;
    pat_tok  = 128'h1;
    pat_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    pat_hs   = {$urandom(), $urandom(), $urandom(), $urandom()};
    repeat (3) tick();
    rst_b = 1'b1;
    tick();

    // Lone token packet with pattern 0x0000001.
    b = g_type.size(); a0 = adv_cnt; d0 = done_cnt; r0 = rdy_cnt;
    reqv[0] = 1'b1;
    wait_quiet(200);
    push_chk("tok_grant_count", g_type.size() - b, 1);
    push_chk("tok_ptype", g_type[b], 1);
    push_chk("tok_adv_cycles", adv_cnt - a0, TOK_BITS);
    push_chk("tok_ready_cycles", rdy_cnt - r0, TOK_BITS + TAIL_BITS);
    push_chk("tok_done_pulses", done_cnt - d0, 1);

    // All three requests rise together.
    b = g_type.size();
    reqv = 3'b111;
    wait_quiet(600);
    push_chk("all_order_0", g_type[b], 3);
    push_chk("all_order_1", g_type[b + 1], 1);
    push_chk("all_order_2", g_type[b + 2], 2);
    push_chk("all_space_hs_tok", g_cyc[b + 1] - g_cyc[b],
             HS_BITS + TAIL_BITS + GAP_BITS + 1);
    push_chk("all_space_tok_data", g_cyc[b + 2] - g_cyc[b + 1],
             TOK_BITS + TAIL_BITS + GAP_BITS + 1);

    // One-cycle data request still yields a full packet.
    bz0 = busy_cnt; a0 = adv_cnt; r0 = rdy_cnt;
    reqv[1] = 1'b1;
    tick();
    reqv[1] = 1'b0;
    wait_quiet(300);
    push_chk("pulse_busy_cycles", busy_cnt - bz0, DATA_BITS + TAIL_BITS + GAP_BITS);
    push_chk("pulse_adv_cycles", adv_cnt - a0, DATA_BITS);
    push_chk("pulse_ready_cycles", rdy_cnt - r0, DATA_BITS + TAIL_BITS);

    // Reset at SEND cycle 40 of a data packet, then a fresh token request.
    reqv[1] = 1'b1;
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (data_gnt) begin ok = 1'b1; break; end
      end
      if (!ok) push_chk("rst_data_grant_timeout", 1, 0);
    end
    repeat (40) tick();
    rst_b = 1'b0;
    tick();
    push_chk("rst_mid_busy", int'(busy), 0);
    push_chk("rst_mid_ready", int'(bstr_out_ready), 0);
    rst_b = 1'b1;
    reqv[0] = 1'b1;
    tick();
    push_chk("rst_regrant_tok", int'(tok_gnt), 1);
    wait_quiet(200);

    // Handshake request raised during the GAP of a token packet.
    b = g_type.size();
    reqv[0] = 1'b1;
    begin
      bit up, ok;
      up = 1'b0; ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        tick();
        if (tok_gnt) up = 1'b1;
        else if (up) begin ok = 1'b1; break; end
      end
      if (!ok) push_chk("gap_tok_timeout", 1, 0);
    end
    reqv[2] = 1'b1;
    wait_quiet(200);
    push_chk("gap_hs_type", g_type[b + 1], 3);
    push_chk("gap_hs_space", g_cyc[b + 1] - g_cyc[b],
             TOK_BITS + TAIL_BITS + GAP_BITS + 1);

    // Random traffic against the model.
    rand_en = 1'b1;
    repeat (3000) tick();
    rand_en = 1'b0;
    wait_quiet(600);

    // tok and data held continuously from reset.
    rst_b = 1'b0;
    repeat (2) tick();
    rst_b = 1'b1;
    b = g_type.size();
    hold_en = 1'b1;
    reqv = 3'b011;
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 800; i++) begin
        tick();
        if (g_type.size() - b >= 4) begin ok = 1'b1; break; end
      end
      if (!ok) push_chk("hold_grant_timeout", 1, 0);
    end
    reqv = 3'b000;
    hold_en = 1'b0;
    wait_quiet(300);
`ifdef USB_SCHED_RR_EN
    push_chk("hold_grant_0", g_type[b], 1);
    push_chk("hold_grant_1", g_type[b + 1], 2);
    push_chk("hold_grant_2", g_type[b + 2], 1);
    push_chk("hold_grant_3", g_type[b + 3], 2);
`else
    push_chk("hold_grant_0", g_type[b], 1);
    push_chk("hold_grant_1", g_type[b + 1], 1);
    push_chk("hold_grant_2", g_type[b + 2], 1);
    push_chk("hold_grant_3", g_type[b + 3], 1);
`endif

    repeat (3) tick();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
